// File: rtl/range_hit_tracker.sv
// range_hit_tracker: windowed per-range hit counts and max data value, plus an in_range3 run alarm.
// Optional feature macro RANGE_MISS_CNT_EN adds miss_o, counting samples with no range flag set.
module range_hit_tracker #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned WINDOW  = 16,
    parameter int unsigned RUN_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       data,
    input  logic             in_range1,
    input  logic             in_range2,
    input  logic             in_range3,
    output logic [CNT_W-1:0] cnt1_o,
    output logic [CNT_W-1:0] cnt2_o,
    output logic [CNT_W-1:0] cnt3_o,
    output logic [3:0]       max_o,
`ifdef RANGE_MISS_CNT_EN
    output logic [CNT_W-1:0] miss_o,
`endif
    output logic             win_done,
    output logic             run_alarm
);

    localparam int unsigned      SMP_W    = $clog2(WINDOW + 1);
    localparam int unsigned      RUN_W    = $clog2(RUN_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(WINDOW - 1);
    localparam logic [RUN_W-1:0] RUN_TOP  = RUN_W'(RUN_LEN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] live1_q, live1_d;
    logic [CNT_W-1:0] live2_q, live2_d;
    logic [CNT_W-1:0] live3_q, live3_d;
    logic [3:0]       live_max_q, live_max_d;
    logic [SMP_W-1:0] smp_q, smp_d;
    logic [RUN_W-1:0] run_q, run_d;

    logic [CNT_W-1:0] cnt1_d, cnt2_d, cnt3_d;
    logic [3:0]       max_d;
    logic             ready_d, done_d, alarm_d;

    logic             accept_c, last_c;
    logic [CNT_W-1:0] inc1_c, inc2_c, inc3_c;
    logic [3:0]       max_c;
    logic [RUN_W-1:0] run_inc_c;

`ifdef RANGE_MISS_CNT_EN
    logic [CNT_W-1:0] live_miss_q, live_miss_d;
    logic [CNT_W-1:0] miss_d;
    logic [CNT_W-1:0] inc_miss_c;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic f);
        return (f && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

    // Candidate values including the current sample, shared by accumulate and report paths
    always_comb begin
        accept_c  = in_valid && in_ready;
        last_c    = accept_c && (smp_q == SMP_LAST);
        inc1_c    = sat_inc(live1_q, in_range1);
        inc2_c    = sat_inc(live2_q, in_range2);
        inc3_c    = sat_inc(live3_q, in_range3);
        max_c     = (data > live_max_q) ? data : live_max_q;
        run_inc_c = (run_q == RUN_TOP) ? run_q : run_q + RUN_W'(1);
`ifdef RANGE_MISS_CNT_EN
        inc_miss_c = sat_inc(live_miss_q, !(in_range1 || in_range2 || in_range3));
`endif
    end

    // Next-state, live accumulators and report loads
    always_comb begin
        state_d    = state_q;
        live1_d    = live1_q;
        live2_d    = live2_q;
        live3_d    = live3_q;
        live_max_d = live_max_q;
        smp_d      = smp_q;
        run_d      = run_q;
        cnt1_d     = cnt1_o;
        cnt2_d     = cnt2_o;
        cnt3_d     = cnt3_o;
        max_d      = max_o;
        done_d     = 1'b0;
`ifdef RANGE_MISS_CNT_EN
        live_miss_d = live_miss_q;
        miss_d      = miss_o;
`endif

        case (state_q)
            IDLE: begin
                live1_d    = '0;
                live2_d    = '0;
                live3_d    = '0;
                live_max_d = '0;
                smp_d      = '0;
                run_d      = '0;
`ifdef RANGE_MISS_CNT_EN
                live_miss_d = '0;
`endif
                if (en) state_d = ACCUM;
            end
            ACCUM: begin
                if (accept_c) begin
                    run_d = in_range3 ? run_inc_c : '0;
                    if (last_c) begin
                        // Final sample: publish totals including it and restart the window
                        cnt1_d     = inc1_c;
                        cnt2_d     = inc2_c;
                        cnt3_d     = inc3_c;
                        max_d      = max_c;
                        done_d     = 1'b1;
                        live1_d    = '0;
                        live2_d    = '0;
                        live3_d    = '0;
                        live_max_d = '0;
                        smp_d      = '0;
`ifdef RANGE_MISS_CNT_EN
                        miss_d      = inc_miss_c;
                        live_miss_d = '0;
`endif
                        state_d    = REPORT;
                    end else begin
                        live1_d    = inc1_c;
                        live2_d    = inc2_c;
                        live3_d    = inc3_c;
                        live_max_d = max_c;
                        smp_d      = smp_q + SMP_W'(1);
`ifdef RANGE_MISS_CNT_EN
                        live_miss_d = inc_miss_c;
`endif
                    end
                end else if (!en) begin
                    state_d = IDLE;
                end
            end
            REPORT: begin
                state_d = en ? ACCUM : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == ACCUM);
        alarm_d = (run_d == RUN_TOP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            live1_q    <= '0;
            live2_q    <= '0;
            live3_q    <= '0;
            live_max_q <= '0;
            smp_q      <= '0;
            run_q      <= '0;
            in_ready   <= 1'b0;
            cnt1_o     <= '0;
            cnt2_o     <= '0;
            cnt3_o     <= '0;
            max_o      <= '0;
            win_done   <= 1'b0;
            run_alarm  <= 1'b0;
`ifdef RANGE_MISS_CNT_EN
            live_miss_q <= '0;
            miss_o      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            live1_q    <= live1_d;
            live2_q    <= live2_d;
            live3_q    <= live3_d;
            live_max_q <= live_max_d;
            smp_q      <= smp_d;
            run_q      <= run_d;
            in_ready   <= ready_d;
            cnt1_o     <= cnt1_d;
            cnt2_o     <= cnt2_d;
            cnt3_o     <= cnt3_d;
            max_o      <= max_d;
            win_done   <= done_d;
            run_alarm  <= alarm_d;
`ifdef RANGE_MISS_CNT_EN
            live_miss_q <= live_miss_d;
            miss_o      <= miss_d;
`endif
        end
    end

endmodule

// File: tb/tb_range_hit_tracker.sv
// Directed bench for range_hit_tracker: default instance plus a CNT_W=4/WINDOW=20 saturation instance.
module tb_range_hit_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       in_valid;
    logic [3:0] data;
    logic       r1, r2, r3;
    logic       en2, valid2;

    logic       in_ready, win_done, run_alarm;
    logic [7:0] cnt1, cnt2, cnt3;
    logic [3:0] max_v;

    logic       in_ready2, win_done2, run_alarm2;
    logic [3:0] cnt1_s, cnt2_s, cnt3_s;
    logic [3:0] max_s;

`ifdef RANGE_MISS_CNT_EN
    logic [7:0] miss;
    logic [3:0] miss_s;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    range_hit_tracker u_dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .data(data), .in_range1(r1), .in_range2(r2), .in_range3(r3),
        .cnt1_o(cnt1), .cnt2_o(cnt2), .cnt3_o(cnt3), .max_o(max_v),
`ifdef RANGE_MISS_CNT_EN
        .miss_o(miss),
`endif
        .win_done(win_done), .run_alarm(run_alarm)
    );

    range_hit_tracker #(.CNT_W(4), .WINDOW(20), .RUN_LEN(3)) u_sat (
        .clk(clk), .rst(rst), .en(en2), .in_valid(valid2), .in_ready(in_ready2),
        .data(data), .in_range1(r1), .in_range2(r2), .in_range3(r3),
        .cnt1_o(cnt1_s), .cnt2_o(cnt2_s), .cnt3_o(cnt3_s), .max_o(max_s),
`ifdef RANGE_MISS_CNT_EN
        .miss_o(miss_s),
`endif
        .win_done(win_done2), .run_alarm(run_alarm2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Comparator flags as the upstream stage would produce them
    task automatic drive(input int d, input logic v);
        data     = 4'(d);
        r1       = (d >= 3) && (d <= 7);
        r2       = (d == 2) || (d == 5) || (d == 9);
        r3       = (d >= 10);
        in_valid = v;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; en2 = 1'b0; valid2 = 1'b0;
        drive(0, 1'b0);

        // Reset and idle
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_ready", 32'(in_ready), 0);
        check("rst_cnt1", 32'(cnt1), 0);
        check("rst_cnt2", 32'(cnt2), 0);
        check("rst_cnt3", 32'(cnt3), 0);
        check("rst_max", 32'(max_v), 0);
        check("rst_done", 32'(win_done), 0);
        check("rst_alarm", 32'(run_alarm), 0);
        drive(12, 1'b1);
        tick(); tick(); tick();
        check("idle_ready", 32'(in_ready), 0);
        check("idle_alarm", 32'(run_alarm), 0);
        check("idle_done", 32'(win_done), 0);

        // Full sweep 0..15
        drive(0, 1'b0);
        en = 1'b1;
        tick();
        check("sweep_ready", 32'(in_ready), 1);
        for (int d = 0; d < 16; d++) begin
            drive(d, 1'b1);
            tick();
            if (d == 14) check("sweep_early_done", 32'(win_done), 0);
        end
        check("sweep_done", 32'(win_done), 1);
        check("sweep_cnt1", 32'(cnt1), 5);
        check("sweep_cnt2", 32'(cnt2), 3);
        check("sweep_cnt3", 32'(cnt3), 6);
        check("sweep_max", 32'(max_v), 15);
        check("sweep_rep_ready", 32'(in_ready), 0);
`ifdef RANGE_MISS_CNT_EN
        check("sweep_miss", 32'(miss), 3);
`endif
        drive(0, 1'b0);
        tick();
        check("post_rep_done", 32'(win_done), 0);
        check("post_rep_ready", 32'(in_ready), 1);
        check("boundary_alarm", 32'(run_alarm), 1);
        check("hold_cnt1", 32'(cnt1), 5);

        // Run alarm with a valid gap
        drive(4, 1'b1);  tick(); check("run_clear", 32'(run_alarm), 0);
        drive(10, 1'b1); tick(); check("run_1", 32'(run_alarm), 0);
        drive(11, 1'b1); tick(); check("run_2", 32'(run_alarm), 0);
        drive(11, 1'b0); tick(); check("run_gap", 32'(run_alarm), 0);
        drive(12, 1'b1); tick(); check("run_rise", 32'(run_alarm), 1);
        drive(4, 1'b1);  tick(); check("run_fall", 32'(run_alarm), 0);

        // Abort after 7 accepts
        drive(4, 1'b1); tick();
        drive(4, 1'b1); tick();
        drive(0, 1'b0); en = 1'b0;
        tick();
        check("abort_ready", 32'(in_ready), 0);
        check("abort_done", 32'(win_done), 0);
        check("abort_hold_cnt1", 32'(cnt1), 5);

        // Clean window of data=2, in_valid held across REPORT
        en = 1'b1;
        drive(2, 1'b1);
        tick();
        for (int i = 0; i < 16; i++) tick();
        check("abort_win_done", 32'(win_done), 1);
        check("abort_win_cnt1", 32'(cnt1), 0);
        check("abort_win_cnt2", 32'(cnt2), 16);
        check("abort_win_cnt3", 32'(cnt3), 0);
        check("abort_win_max", 32'(max_v), 2);
        check("bp_rep_ready", 32'(in_ready), 0);
        drive(9, 1'b1);
        for (int i = 0; i < 16; i++) tick();
        check("bp_not_early", 32'(win_done), 0);
        tick();
        check("bp_done", 32'(win_done), 1);
        check("bp_cnt2", 32'(cnt2), 16);
        check("bp_max", 32'(max_v), 9);
`ifdef RANGE_MISS_CNT_EN
        check("bp_miss", 32'(miss), 0);
`endif

        // Reset on the 7th accept of a window
        drive(12, 1'b0);
        tick();
        drive(12, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        check("pre_rst_alarm", 32'(run_alarm), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_done", 32'(win_done), 0);
        check("mid_rst_cnt2", 32'(cnt2), 0);
        check("mid_rst_alarm", 32'(run_alarm), 0);
        check("mid_rst_ready", 32'(in_ready), 0);
        drive(2, 1'b1);
        tick();
        for (int i = 0; i < 16; i++) tick();
        check("rst_win_done", 32'(win_done), 1);
        check("rst_win_cnt2", 32'(cnt2), 16);
        check("rst_win_cnt3", 32'(cnt3), 0);
        check("rst_win_max", 32'(max_v), 2);

        // Saturation on the CNT_W=4, WINDOW=20 instance
        en = 1'b0;
        drive(4, 1'b0);
        tick(); tick();
        en2 = 1'b1; valid2 = 1'b1;
        tick();
        for (int i = 0; i < 19; i++) tick();
        check("sat_early_done", 32'(win_done2), 0);
        tick();
        check("sat_done", 32'(win_done2), 1);
        check("sat_cnt1", 32'(cnt1_s), 15);
        check("sat_cnt2", 32'(cnt2_s), 0);
        check("sat_max", 32'(max_s), 4);
        check("sat_main_idle", 32'(win_done), 0);
        en2 = 1'b0; valid2 = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
